// File: rtl/sdr_cfg_ctrl.sv
// Configuration controller for the SDRAM controller: staged profiles behind a
// single-cycle register bus, switched in atomically on a software commit.
module sdr_cfg_ctrl #(
  parameter int unsigned SDR_REFRESH_TIMER_W   = 12,
  parameter int unsigned SDR_REFRESH_ROW_CNT_W = 3,
  parameter int unsigned NUM_PROFILES          = 2,
  parameter int unsigned AW                    = 6,
  parameter int unsigned INIT_TIMEOUT          = 65535
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             cfg_req_i,
  input  logic                             cfg_we_i,
  input  logic [AW-1:0]                    cfg_addr_i,
  input  logic [31:0]                      cfg_wdata_i,
  output logic [31:0]                      cfg_rdata_o,
  output logic                             cfg_ack_o,
  input  logic                             sdr_idle_i,
  input  logic                             sdr_init_done_i,
  output logic [1:0]                       cfg_sdr_width,
  output logic [1:0]                       cfg_colbits,
  output logic [3:0]                       cfg_sdr_tras_d,
  output logic [3:0]                       cfg_sdr_trp_d,
  output logic [3:0]                       cfg_sdr_trcd_d,
  output logic                             cfg_sdr_en,
  output logic [1:0]                       cfg_req_depth,
  output logic [12:0]                      cfg_sdr_mode_reg,
  output logic [2:0]                       cfg_sdr_cas,
  output logic [3:0]                       cfg_sdr_trcar_d,
  output logic [3:0]                       cfg_sdr_twr_d,
  output logic [SDR_REFRESH_TIMER_W-1:0]   cfg_sdr_rfsh,
  output logic [SDR_REFRESH_ROW_CNT_W-1:0] cfg_sdr_rfmax,
  output logic                             cfg_busy_o,
  output logic                             cfg_irq_o
);
  localparam int unsigned TW = SDR_REFRESH_TIMER_W;
  localparam int unsigned RW = SDR_REFRESH_ROW_CNT_W;
  localparam int unsigned CW = 17;
  localparam int unsigned PW = AW - 2;

  typedef struct packed {
    logic [3:0]    tras;
    logic [3:0]    trp;
    logic [3:0]    trcd;
    logic [3:0]    trcar;
    logic [3:0]    twr;
    logic [2:0]    cas;
    logic [1:0]    width;
    logic [1:0]    colbits;
    logic [1:0]    req_depth;
    logic [12:0]   mode_reg;
    logic [TW-1:0] rfsh;
    logic [RW-1:0] rfmax;
  } prof_t;

  localparam prof_t PROF_DEF = '{tras: 4'd4, trp: 4'd2, trcd: 4'd2, trcar: 4'd7, twr: 4'd1,
                                 cas: 3'd3, width: 2'b01, colbits: 2'd0, req_depth: 2'd3,
                                 mode_reg: 13'h033, rfsh: TW'(32'h100), rfmax: RW'(32'd6)};

  typedef enum logic [2:0] {S_IDLE, S_QUIESCE, S_LOAD, S_REINIT, S_DONE} state_t;

  function automatic logic [31:0] word0(input prof_t p);
    return {2'b00, p.req_depth, p.colbits, p.width, 1'b0, p.cas,
            p.twr, p.trcar, p.trcd, p.trp, p.tras};
  endfunction

  state_t          state, state_n;
  prof_t           prof [NUM_PROFILES];
  prof_t           act, sel_prof, rd_prof;
  logic [3:0]      act_idx, tgt_q, ctrl_tgt;
  logic            en_req, sdr_en, sdr_en_n, busy, busy_n, irq, irq_n;
  logic            err_busy, err_busy_n, err_to, err_to_n, load, start;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [31:0]     rdata_n;
  logic            accept, wr, ctrl_wr, stat_wr, prof_hit, tgt_ok;
  logic [AW-1:0]   addr_off;
  logic [PW-1:0]   prof_sel;
  logic [1:0]      prof_word;
  logic            unused_wdata;

  // Bus decode; a request is not taken while its predecessor is being acked
  assign accept    = cfg_req_i && !cfg_ack_o;
  assign wr        = accept && cfg_we_i;
  assign ctrl_wr   = wr && (cfg_addr_i == AW'(0));
  assign stat_wr   = wr && (cfg_addr_i == AW'(1));
  assign addr_off  = cfg_addr_i - AW'(4);
  assign prof_sel  = addr_off[AW-1:2];
  assign prof_word = addr_off[1:0];
  assign prof_hit  = (cfg_addr_i >= AW'(4)) && (32'(prof_sel) < NUM_PROFILES);
  assign tgt_ok    = 32'(cfg_wdata_i[7:4]) < NUM_PROFILES;
  assign cnt_inc   = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  assign unused_wdata = ^{cfg_wdata_i[31:30], cfg_wdata_i[23]};

  for (genvar g = 0; g < int'(NUM_PROFILES); g++) begin : g_prof
    prof_t q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        q <= PROF_DEF;
      end else if (wr && prof_hit && prof_sel == PW'(g)) begin
        case (prof_word)
          2'd0: begin
            q.tras      <= cfg_wdata_i[3:0];
            q.trp       <= cfg_wdata_i[7:4];
            q.trcd      <= cfg_wdata_i[11:8];
            q.trcar     <= cfg_wdata_i[15:12];
            q.twr       <= cfg_wdata_i[19:16];
            q.cas       <= cfg_wdata_i[22:20];
            q.width     <= cfg_wdata_i[25:24];
            q.colbits   <= cfg_wdata_i[27:26];
            q.req_depth <= cfg_wdata_i[29:28];
          end
          2'd1:    q.mode_reg <= cfg_wdata_i[12:0];
          2'd2:    q.rfsh     <= cfg_wdata_i[TW-1:0];
          default: q.rfmax    <= cfg_wdata_i[RW-1:0];
        endcase
      end
    end
    assign prof[g] = q;
  end

  // Profile muxes: latched commit target and bus read selection
  always_comb begin
    sel_prof = PROF_DEF;
    rd_prof  = PROF_DEF;
    for (int unsigned p = 0; p < NUM_PROFILES; p++) begin
      if (tgt_q == 4'(p))    sel_prof = prof[p];
      if (prof_sel == PW'(p)) rd_prof = prof[p];
    end
  end

  always_comb begin
    rdata_n = '0;
    if (cfg_addr_i == AW'(0)) begin
      rdata_n = 32'({en_req, ctrl_tgt, 4'b0000});
    end else if (cfg_addr_i == AW'(1)) begin
      rdata_n = 32'({act_idx, err_to, err_busy, sdr_init_done_i, busy});
    end else if (prof_hit) begin
      case (prof_word)
        2'd0:    rdata_n = word0(rd_prof);
        2'd1:    rdata_n = 32'(rd_prof.mode_reg);
        2'd2:    rdata_n = 32'(rd_prof.rfsh);
        default: rdata_n = 32'(rd_prof.rfmax);
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    sdr_en_n   = sdr_en;
    busy_n     = busy;
    irq_n      = 1'b0;
    cnt_n      = cnt;
    err_busy_n = err_busy;
    err_to_n   = err_to;
    load       = 1'b0;
    start      = 1'b0;
    if (stat_wr && cfg_wdata_i[2]) err_busy_n = 1'b0;
    if (stat_wr && cfg_wdata_i[3]) err_to_n   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (ctrl_wr) begin
          if (cfg_wdata_i[0] && tgt_ok) begin
            state_n  = S_QUIESCE;
            busy_n   = 1'b1;
            sdr_en_n = 1'b0;
            start    = 1'b1;
          end else if (cfg_wdata_i[0]) begin
            err_busy_n = 1'b1;
          end else begin
            sdr_en_n = cfg_wdata_i[8];
          end
        end
      end
      S_QUIESCE: begin
        sdr_en_n = 1'b0;
        if (ctrl_wr)    err_busy_n = 1'b1;
        if (sdr_idle_i) state_n    = S_LOAD;
      end
      S_LOAD: begin
        load = 1'b1;
        if (ctrl_wr) err_busy_n = 1'b1;
        if (en_req) begin
          state_n  = S_REINIT;
          sdr_en_n = 1'b1;
          cnt_n    = '0;
        end else begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          irq_n   = 1'b1;
        end
      end
      S_REINIT: begin
        // First two cycles ignore a stale init_done level from before the switch
        cnt_n = cnt_inc;
        if (ctrl_wr) err_busy_n = 1'b1;
        if (cnt >= CW'(2) && sdr_init_done_i) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          irq_n   = 1'b1;
        end else if (cnt_inc >= CW'(INIT_TIMEOUT)) begin
          state_n  = S_DONE;
          busy_n   = 1'b0;
          irq_n    = 1'b1;
          sdr_en_n = 1'b0;
          err_to_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      sdr_en      <= 1'b0;
      busy        <= 1'b0;
      irq         <= 1'b0;
      err_busy    <= 1'b0;
      err_to      <= 1'b0;
      cnt         <= '0;
      act         <= PROF_DEF;
      act_idx     <= '0;
      tgt_q       <= '0;
      ctrl_tgt    <= '0;
      en_req      <= 1'b0;
      cfg_ack_o   <= 1'b0;
      cfg_rdata_o <= '0;
    end else begin
      state     <= state_n;
      sdr_en    <= sdr_en_n;
      busy      <= busy_n;
      irq       <= irq_n;
      err_busy  <= err_busy_n;
      err_to    <= err_to_n;
      cnt       <= cnt_n;
      cfg_ack_o <= accept;
      if (accept) cfg_rdata_o <= rdata_n;
      if (ctrl_wr) begin
        en_req   <= cfg_wdata_i[8];
        ctrl_tgt <= cfg_wdata_i[7:4];
      end
      if (start) tgt_q <= cfg_wdata_i[7:4];
      if (load) begin
        act     <= sel_prof;
        act_idx <= tgt_q;
      end
    end
  end

  assign cfg_sdr_tras_d   = act.tras;
  assign cfg_sdr_trp_d    = act.trp;
  assign cfg_sdr_trcd_d   = act.trcd;
  assign cfg_sdr_trcar_d  = act.trcar;
  assign cfg_sdr_twr_d    = act.twr;
  assign cfg_sdr_cas      = act.cas;
  assign cfg_sdr_width    = act.width;
  assign cfg_colbits      = act.colbits;
  assign cfg_req_depth    = act.req_depth;
  assign cfg_sdr_mode_reg = act.mode_reg;
  assign cfg_sdr_rfsh     = act.rfsh;
  assign cfg_sdr_rfmax    = act.rfmax;
  assign cfg_sdr_en       = sdr_en;
  assign cfg_busy_o       = busy;
  assign cfg_irq_o        = irq;
endmodule

// File: tb/tb_sdr_cfg_ctrl.sv
// Bench for sdr_cfg_ctrl: register table, directed commit sequences and a
// randomized bus/commit mix checked against a word-level register model.
module tb_sdr_cfg_ctrl;
  localparam int unsigned TW = 12;
  localparam int unsigned RW = 3;
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 6;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ack;
  logic          idle = 1'b0, init_done = 1'b0;
  logic [1:0]    width, colbits, req_depth;
  logic [3:0]    tras, trp, trcd, trcar, twr;
  logic          en, busy, irq;
  logic [12:0]   mode_reg;
  logic [2:0]    cas;
  logic [TW-1:0] rfsh;
  logic [RW-1:0] rfmax;

  int n_tests = 0;
  int n_fail  = 0;
  int irq_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (irq) irq_seen++;

  sdr_cfg_ctrl #(.SDR_REFRESH_TIMER_W(TW), .SDR_REFRESH_ROW_CNT_W(RW), .NUM_PROFILES(NP),
                 .AW(AW), .INIT_TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_req_i(req), .cfg_we_i(we), .cfg_addr_i(addr),
    .cfg_wdata_i(wdata), .cfg_rdata_o(rdata), .cfg_ack_o(ack), .sdr_idle_i(idle),
    .sdr_init_done_i(init_done), .cfg_sdr_width(width), .cfg_colbits(colbits),
    .cfg_sdr_tras_d(tras), .cfg_sdr_trp_d(trp), .cfg_sdr_trcd_d(trcd), .cfg_sdr_en(en),
    .cfg_req_depth(req_depth), .cfg_sdr_mode_reg(mode_reg), .cfg_sdr_cas(cas),
    .cfg_sdr_trcar_d(trcar), .cfg_sdr_twr_d(twr), .cfg_sdr_rfsh(rfsh), .cfg_sdr_rfmax(rfmax),
    .cfg_busy_o(busy), .cfg_irq_o(irq));

  // Reference model: profile registers as masked 32-bit words
  logic [31:0] prof_m [NP][4];
  logic [31:0] act_m [4];
  int          act_p = 0;

  function automatic logic [31:0] mask_w(input int w);
    case (w)
      0:       return 32'h3F7F_FFFF;
      1:       return 32'h0000_1FFF;
      2:       return (32'd1 << TW) - 32'd1;
      default: return (32'd1 << RW) - 32'd1;
    endcase
  endfunction

  function automatic logic [31:0] def_w(input int w);
    case (w)
      0:       return 32'h3131_7224;
      1:       return 32'h0000_0033;
      2:       return 32'h100 & mask_w(2);
      default: return 32'd6 & mask_w(3);
    endcase
  endfunction

  function automatic logic [31:0] out_w(input int w);
    case (w)
      0:       return {2'b00, req_depth, colbits, width, 1'b0, cas, twr, trcar, trcd, trp, tras};
      1:       return 32'(mode_reg);
      2:       return 32'(rfsh);
      default: return 32'(rfmax);
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a >= 4 && (a - 4) / 4 < int'(NP)) return prof_m[(a - 4) / 4][(a - 4) % 4];
    return 32'h0;
  endfunction

  task automatic model_write(input int a, input logic [31:0] d);
    if (a >= 4 && (a - 4) / 4 < int'(NP)) prof_m[(a - 4) / 4][(a - 4) % 4] = d & mask_w((a - 4) % 4);
  endtask

  task automatic model_reset();
    for (int p = 0; p < int'(NP); p++)
      for (int w = 0; w < 4; w++) prof_m[p][w] = def_w(w);
    for (int w = 0; w < 4; w++) act_m[w] = def_w(w);
    act_p = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic chk_active(input string tag);
    for (int w = 0; w < 4; w++) chk($sformatf("%s_w%0d", tag, w), out_w(w), act_m[w]);
  endtask

  task automatic bus(input logic w, input int a, input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; addr = AW'(a); wdata = d;
    @(negedge clk);
    chk("ack_high", 32'(ack), 32'd1);
    rd  = rdata;
    req = 1'b0;
    @(negedge clk);
    chk("ack_low", 32'(ack), 32'd0);
  endtask

  function automatic logic [31:0] status_w(input int ap, input logic et, input logic eb,
                                           input logic id, input logic bz);
    return 32'({4'(ap), et, eb, id, bz});
  endfunction

  typedef struct {
    logic        w;
    int          a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] rd;
  int          cnt, irq0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 8'h08, 32'h0,         32'h3131_7224};
    vecs[1]  = '{1'b1, 8'h08, 32'h02A5_4321, 32'h0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,         32'h0225_4321};
    vecs[3]  = '{1'b1, 8'h09, 32'hFFFF_FFFF, 32'h0};
    vecs[4]  = '{1'b0, 8'h09, 32'h0,         32'h0000_1FFF};
    vecs[5]  = '{1'b1, 8'h0A, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b0, 8'h0A, 32'h0,         32'h0000_0FFF};
    vecs[7]  = '{1'b1, 8'h0B, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 8'h0B, 32'h0,         32'h0000_0007};
    vecs[9]  = '{1'b0, 8'h04, 32'h0,         32'h3131_7224};
    vecs[10] = '{1'b1, 8'h02, 32'hDEAD_BEEF, 32'h0};
    vecs[11] = '{1'b0, 8'h02, 32'h0,         32'h0};
    vecs[12] = '{1'b1, 8'h0C, 32'h0000_1234, 32'h0};
    vecs[13] = '{1'b0, 8'h0C, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 8'h3F, 32'h0,         32'h0};

    // Power-on reset
    model_reset();
    repeat (2) @(negedge clk);
    chk_active("rst");
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    bus(1'b0, 1, 32'h0, rd);
    chk("rst_status", rd, status_w(0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Register table
    for (int i = 0; i < 15; i++) begin
      bus(vecs[i].w, vecs[i].a, vecs[i].d, rd);
      if (vecs[i].w) model_write(vecs[i].a, vecs[i].d);
      else chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    chk_active("tbl_hold");

    // Direct enable outside a commit
    bus(1'b1, 0, 32'h100, rd);
    chk("en_direct", 32'(en), 32'd1);
    bus(1'b0, 0, 32'h0, rd);
    chk("ctrl_read", rd, 32'h100);

    // Back-to-back request throughput
    @(negedge clk); req = 1'b1; we = 1'b0; addr = AW'(4);
    @(negedge clk); chk("b2b_ack1", 32'(ack), 32'd1);
    @(negedge clk); chk("b2b_gap", 32'(ack), 32'd0);
    @(negedge clk); chk("b2b_ack2", 32'(ack), 32'd1); req = 1'b0;
    @(negedge clk); chk("b2b_end", 32'(ack), 32'd0);

    // Commit to profile 1 with a slow quiesce and a busy collision
    bus(1'b1, 0, 32'h111, rd);
    chk("q_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("q_en_low", 32'(en), 32'd0);
      chk("q_old_w0", out_w(0), act_m[0]);
    end
    bus(1'b1, 0, 32'h111, rd);
    bus(1'b0, 1, 32'h0, rd);
    chk("coll_status", rd, status_w(0, 1'b0, 1'b1, 1'b0, 1'b1));
    bus(1'b1, 1, 32'h4, rd);
    bus(1'b0, 1, 32'h0, rd);
    chk("coll_clear", rd, status_w(0, 1'b0, 1'b0, 1'b0, 1'b1));
    idle = 1'b1;
    @(negedge clk);
    chk("load_pending_w0", out_w(0), act_m[0]);
    @(negedge clk);
    for (int w = 0; w < 4; w++) act_m[w] = prof_m[1][w];
    act_p = 1;
    chk_active("load");
    chk("reinit_en", 32'(en), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("reinit_busy", 32'(busy), 32'd1);
      chk("reinit_irq", 32'(irq), 32'd0);
    end
    irq0 = irq_seen;
    init_done = 1'b1;
    @(negedge clk);
    chk("done_irq", 32'(irq), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_irq_off", 32'(irq), 32'd0);
    bus(1'b0, 1, 32'h0, rd);
    chk("done_status", rd, status_w(1, 1'b0, 1'b0, 1'b1, 1'b0));
    chk("done_irq_once", 32'(irq_seen - irq0), 32'd1);
    init_done = 1'b0;

    // Re-init timeout on profile 0
    irq0 = irq_seen;
    bus(1'b1, 0, 32'h101, rd);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en) cnt++;
      if (!busy) break;
    end
    chk("to_finished", 32'(busy), 32'd0);
    chk("to_en_cycles", 32'(cnt), 32'(TO));
    chk("to_en_off", 32'(en), 32'd0);
    for (int w = 0; w < 4; w++) act_m[w] = prof_m[0][w];
    act_p = 0;
    chk_active("to");
    bus(1'b0, 1, 32'h0, rd);
    chk("to_status", rd, status_w(0, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("to_irq_once", 32'(irq_seen - irq0), 32'd1);
    bus(1'b1, 1, 32'h8, rd);
    bus(1'b0, 1, 32'h0, rd);
    chk("to_clear", rd, 32'h0);

    // Illegal commit target
    bus(1'b1, 0, 32'h051, rd);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_en", 32'(en), 32'd0);
    bus(1'b0, 1, 32'h0, rd);
    chk("ill_status", rd, status_w(0, 1'b0, 1'b1, 1'b0, 1'b0));
    chk_active("ill");
    bus(1'b1, 1, 32'h4, rd);

    // Randomized mix against the model
    idle = 1'b1;
    init_done = 1'b1;
    for (int it = 0; it < 150; it++) begin
      int r, a, tgt;
      logic [31:0] d;
      logic ebit;
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        a = int'($urandom_range(2, 63));
        d = $urandom;
        bus(1'b1, a, d, rd);
        model_write(a, d);
        chk_active("rnd_hold");
      end else if (r < 7) begin
        a = int'($urandom_range(2, 63));
        bus(1'b0, a, 32'h0, rd);
        chk($sformatf("rnd_rd_%0h", a), rd, model_read(a));
      end else begin
        tgt  = int'($urandom_range(0, 3));
        ebit = 1'($urandom_range(0, 1));
        bus(1'b1, 0, (32'(ebit) << 8) | (32'(tgt) << 4) | 32'h1, rd);
        if (tgt < int'(NP)) begin
          for (int i = 0; i < 40 && busy; i++) @(negedge clk);
          chk("rnd_commit_done", 32'(busy), 32'd0);
          for (int w = 0; w < 4; w++) act_m[w] = prof_m[tgt][w];
          act_p = tgt;
          chk_active("rnd_commit");
          chk("rnd_en", 32'(en), 32'(ebit));
          bus(1'b0, 1, 32'h0, rd);
          chk("rnd_status", rd, status_w(act_p, 1'b0, 1'b0, 1'b1, 1'b0));
        end else begin
          chk("rnd_ill_busy", 32'(busy), 32'd0);
          bus(1'b0, 1, 32'h0, rd);
          chk("rnd_ill_status", rd, status_w(act_p, 1'b0, 1'b1, 1'b1, 1'b0));
          chk_active("rnd_ill");
          bus(1'b1, 1, 32'h4, rd);
        end
      end
    end

    // Asynchronous reset in the middle of a commit
    idle = 1'b0;
    bus(1'b1, 0, 32'h111, rd);
    chk("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_active("arst");
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 1, 32'h0, rd);
    chk("arst_status", rd, status_w(0, 1'b0, 1'b0, 1'b1, 1'b0));
    bus(1'b0, 8, 32'h0, rd);
    chk("arst_prof1", rd, def_w(0));
    bus(1'b0, 0, 32'h0, rd);
    chk("arst_ctrl", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
